// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Stall/flush controller for the five-stage MIPS32 pipeline.
//            Merges ID/EX/MEM stall requests, runs the multi-cycle EX
//            counter and defers flushes until a MEM bus transaction ends.
// Options  : PIPE_CTRL_PERF_EN adds perf_clr, perf_stall_cycles and
//            perf_flush_cnt (saturating stall-cycle and flush counters).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        ex_mc_start,
  input  logic [3:0]  ex_mc_len,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
`ifdef PIPE_CTRL_PERF_EN
  input  logic        perf_clr,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mc_busy,
  output logic        mc_last
);

  // Stall vectors: bit0=PC .. bit4=MEM/WB, bit5 mirrors bit4
  localparam logic [5:0] c_stall_none = 6'b000000;
  localparam logic [5:0] c_stall_id   = 6'b000111;
  localparam logic [5:0] c_stall_ex   = 6'b001111;
  localparam logic [5:0] c_stall_mem  = 6'b111111;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_MULTI  = 2'd1,
    S_PFLUSH = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_mc_cnt;
  logic [31:0] r_pend_pc;

  state_t      w_state_nxt;
  logic [3:0]  w_mc_cnt_nxt;
  logic [31:0] w_pend_pc_nxt;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic        w_mc_busy;
  logic        w_mc_last;

  // Next-state and same-cycle stall/flush decode from requests and state
  always_comb begin
    w_state_nxt   = r_state;
    w_mc_cnt_nxt  = r_mc_cnt;
    w_pend_pc_nxt = r_pend_pc;
    w_stall       = c_stall_none;
    w_flush       = 1'b0;
    w_new_pc      = 32'd0;
    w_mc_busy     = 1'b0;
    w_mc_last     = 1'b0;

    case (r_state)
      S_RUN: begin
        if (flush_req && !stallreq_mem) begin
          w_flush  = 1'b1;
          w_new_pc = flush_pc;
        end else if (flush_req) begin
          // Bus is mid-transaction: remember the target, flush once it frees
          w_pend_pc_nxt = flush_pc;
          w_state_nxt   = S_PFLUSH;
          w_stall       = c_stall_mem;
        end else if (stallreq_mem) begin
          w_stall = c_stall_mem;
        end else if (ex_mc_start && (ex_mc_len != 4'd0)) begin
          w_stall = c_stall_ex;
          if (ex_mc_len == 4'd1) begin
            w_mc_last = 1'b1;
          end else begin
            // This cycle is the first of N, so N-1 remain in MULTI
            w_mc_cnt_nxt = ex_mc_len - 4'd1;
            w_state_nxt  = S_MULTI;
          end
        end else if (stallreq_ex) begin
          w_stall = c_stall_ex;
        end else if (stallreq_id) begin
          w_stall = c_stall_id;
        end
      end

      S_MULTI: begin
        w_mc_busy = 1'b1;
        if (flush_req && !stallreq_mem) begin
          w_flush      = 1'b1;
          w_new_pc     = flush_pc;
          w_mc_cnt_nxt = 4'd0;
          w_state_nxt  = S_RUN;
        end else if (flush_req) begin
          w_pend_pc_nxt = flush_pc;
          w_mc_cnt_nxt  = 4'd0;
          w_state_nxt   = S_PFLUSH;
          w_stall       = c_stall_mem;
        end else if (stallreq_mem) begin
          // Counter holds while the MEM stage is waiting on the bus
          w_stall = c_stall_mem;
        end else begin
          w_stall = c_stall_ex;
          if (r_mc_cnt <= 4'd1) begin
            w_mc_last    = 1'b1;
            w_mc_cnt_nxt = 4'd0;
            w_state_nxt  = S_RUN;
          end else begin
            w_mc_cnt_nxt = r_mc_cnt - 4'd1;
          end
        end
      end

      S_PFLUSH: begin
        // New flush requests are dropped here; the older one wins
        if (stallreq_mem) begin
          w_stall = c_stall_mem;
        end else begin
          w_flush     = 1'b1;
          w_new_pc    = r_pend_pc;
          w_state_nxt = S_RUN;
        end
      end

      default: begin
        w_state_nxt  = S_RUN;
        w_mc_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Controller state: FSM, multi-cycle counter and pending redirect PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_RUN;
      r_mc_cnt  <= 4'd0;
      r_pend_pc <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_mc_cnt  <= w_mc_cnt_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  // Outputs are held at zero for as long as reset is asserted
  assign stall   = rst ? w_stall   : c_stall_none;
  assign flush   = rst ? w_flush   : 1'b0;
  assign new_pc  = rst ? w_new_pc  : 32'd0;
  assign mc_busy = rst ? w_mc_busy : 1'b0;
  assign mc_last = rst ? w_mc_last : 1'b0;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating counters of PC-stall cycles and flush cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else if (perf_clr) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (stall[0] && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_cnt    = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Directed self-checking bench for pipe_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        ex_mc_start;
  logic [3:0]  ex_mc_len;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_last;
`ifdef PIPE_CTRL_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_len    (ex_mc_len),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
`ifdef PIPE_CTRL_PERF_EN
    .perf_clr          (perf_clr),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt),
`endif
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mc_busy      (mc_busy),
    .mc_last      (mc_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all request inputs inactive
  task automatic idle();
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    ex_mc_start  = 1'b0;
    ex_mc_len    = 4'd0;
    flush_req    = 1'b0;
    flush_pc     = 32'd0;
`ifdef PIPE_CTRL_PERF_EN
    perf_clr     = 1'b0;
`endif
  endtask

  // Move to just after the next rising edge (input drive point)
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    stallreq_mem = 1'b1;
    flush_req    = 1'b1;
    flush_pc     = 32'hFFFF_FFFF;
    ex_mc_start  = 1'b1;
    ex_mc_len    = 4'd5;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000 || flush !== 1'b0 || new_pc !== 32'd0 ||
        mc_busy !== 1'b0 || mc_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b flush=%b new_pc=%h busy=%b last=%b, want all 0",
               stall, flush, new_pc, mc_busy, mc_last);
    end
    next_cycle();
    rst = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000 || flush !== 1'b0 || mc_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: stall=%b flush=%b busy=%b, want 0/0/0", stall, flush, mc_busy);
    end
    next_cycle();
  endtask

  task automatic test_multi_cycle();
    // len=4: four EX-stall cycles, last flagged on cycle 4, busy on 2..4
    for (int c = 1; c <= 5; c++) begin
      idle();
      if (c == 1) begin
        ex_mc_start = 1'b1;
        ex_mc_len   = 4'd4;
      end
      @(negedge clk);
      checks++;
      if (stall !== ((c <= 4) ? 6'b001111 : 6'b000000) ||
          mc_last !== (c == 4) || mc_busy !== (c >= 2 && c <= 4)) begin
        errors++;
        $display("FAIL multi_len4 c%0d: stall=%b last=%b busy=%b", c, stall, mc_last, mc_busy);
      end
      next_cycle();
    end
    // len=0 is ignored
    idle();
    ex_mc_start = 1'b1;
    ex_mc_len   = 4'd0;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000 || mc_last !== 1'b0) begin
      errors++;
      $display("FAIL multi_len0: stall=%b last=%b, want 000000/0", stall, mc_last);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (mc_busy !== 1'b0) begin
      errors++;
      $display("FAIL multi_len0_busy: busy=%b, want 0", mc_busy);
    end
    next_cycle();
    // len=1: one EX stall with mc_last, never enters MULTI
    ex_mc_start = 1'b1;
    ex_mc_len   = 4'd1;
    @(negedge clk);
    checks++;
    if (stall !== 6'b001111 || mc_last !== 1'b1 || mc_busy !== 1'b0) begin
      errors++;
      $display("FAIL multi_len1: stall=%b last=%b busy=%b, want 001111/1/0", stall, mc_last, mc_busy);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000 || mc_busy !== 1'b0) begin
      errors++;
      $display("FAIL multi_len1_after: stall=%b busy=%b, want 000000/0", stall, mc_busy);
    end
    next_cycle();
  endtask

  task automatic test_priority();
    idle();
    stallreq_id = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000111) begin
      errors++;
      $display("FAIL prio_id: stall=%b want 000111", stall);
    end
    stallreq_ex = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b001111) begin
      errors++;
      $display("FAIL prio_id_ex: stall=%b want 001111", stall);
    end
    stallreq_mem = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b111111) begin
      errors++;
      $display("FAIL prio_mem: stall=%b want 111111", stall);
    end
    stallreq_mem = 1'b0;
    flush_req    = 1'b1;
    flush_pc     = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000 || flush !== 1'b1 || new_pc !== 32'h1234_5678) begin
      errors++;
      $display("FAIL prio_flush: stall=%b flush=%b new_pc=%h, want 000000/1/12345678",
               stall, flush, new_pc);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'd0 || stall !== 6'b000000) begin
      errors++;
      $display("FAIL prio_after_flush: flush=%b new_pc=%h stall=%b, want 0/0/0", flush, new_pc, stall);
    end
    next_cycle();
  endtask

  task automatic test_mem_freeze();
    logic [5:0] exp_stall;
    for (int c = 1; c <= 6; c++) begin
      idle();
      if (c == 1) begin
        ex_mc_start = 1'b1;
        ex_mc_len   = 4'd3;
      end
      if (c == 2 || c == 3) stallreq_mem = 1'b1;
      case (c)
        1, 4, 5: exp_stall = 6'b001111;
        2, 3:    exp_stall = 6'b111111;
        default: exp_stall = 6'b000000;
      endcase
      @(negedge clk);
      checks++;
      if (stall !== exp_stall || mc_last !== (c == 5)) begin
        errors++;
        $display("FAIL mem_freeze c%0d: stall=%b last=%b, want %b/%0d", c, stall, mc_last,
                 exp_stall, (c == 5));
      end
      next_cycle();
    end
  endtask

  task automatic test_pending_flush();
    for (int c = 1; c <= 5; c++) begin
      idle();
      if (c == 1) begin
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0040;
      end
      if (c == 2) begin
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0080;
      end
      if (c <= 3) stallreq_mem = 1'b1;
      @(negedge clk);
      checks++;
      if (c <= 3) begin
        if (flush !== 1'b0 || stall !== 6'b111111) begin
          errors++;
          $display("FAIL pflush_wait c%0d: flush=%b stall=%b, want 0/111111", c, flush, stall);
        end
      end else if (c == 4) begin
        if (flush !== 1'b1 || new_pc !== 32'h0000_0040 || stall !== 6'b000000) begin
          errors++;
          $display("FAIL pflush_fire: flush=%b new_pc=%h stall=%b, want 1/00000040/000000",
                   flush, new_pc, stall);
        end
      end else begin
        if (flush !== 1'b0 || new_pc !== 32'd0) begin
          errors++;
          $display("FAIL pflush_after: flush=%b new_pc=%h, want 0/0", flush, new_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush_abort_multi();
`ifdef PIPE_CTRL_PERF_EN
    idle();
    perf_clr = 1'b1;
    next_cycle();
`endif
    for (int c = 1; c <= 3; c++) begin
      idle();
      if (c == 1) begin
        ex_mc_start = 1'b1;
        ex_mc_len   = 4'd6;
      end
      if (c == 2) begin
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0100;
      end
      @(negedge clk);
      checks++;
      case (c)
        1: if (stall !== 6'b001111 || mc_last !== 1'b0) begin
             errors++;
             $display("FAIL abort_start: stall=%b last=%b, want 001111/0", stall, mc_last);
           end
        2: if (flush !== 1'b1 || new_pc !== 32'h0000_0100 || stall !== 6'b000000 ||
               mc_last !== 1'b0) begin
             errors++;
             $display("FAIL abort_flush: flush=%b new_pc=%h stall=%b last=%b, want 1/00000100/000000/0",
                      flush, new_pc, stall, mc_last);
           end
        default: if (mc_busy !== 1'b0 || mc_last !== 1'b0 || stall !== 6'b000000) begin
             errors++;
             $display("FAIL abort_after: busy=%b last=%b stall=%b, want 0/0/000000",
                      mc_busy, mc_last, stall);
           end
      endcase
`ifdef PIPE_CTRL_PERF_EN
      if (c == 3) begin
        checks++;
        if (perf_flush_cnt !== 32'd1 || perf_stall_cycles !== 32'd1) begin
          errors++;
          $display("FAIL abort_perf: flush_cnt=%0d stall_cycles=%0d, want 1/1",
                   perf_flush_cnt, perf_stall_cycles);
        end
      end
`endif
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_multi();
    for (int c = 1; c <= 3; c++) begin
      idle();
      if (c == 1) begin
        ex_mc_start = 1'b1;
        ex_mc_len   = 4'd5;
      end
      if (c == 3) rst = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (mc_busy !== 1'b1 || stall !== 6'b001111) begin
          errors++;
          $display("FAIL rstmid_busy: busy=%b stall=%b, want 1/001111", mc_busy, stall);
        end
      end
      if (c == 3) begin
        checks++;
        if (stall !== 6'b000000 || mc_busy !== 1'b0 || mc_last !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_asserted: stall=%b busy=%b last=%b, want 0/0/0",
                   stall, mc_busy, mc_last);
        end
      end
      next_cycle();
    end
    rst = 1'b1;
    idle();
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 6'b000000 || mc_busy !== 1'b0 || mc_last !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_release c%0d: stall=%b busy=%b last=%b, want 0/0/0",
                 c, stall, mc_busy, mc_last);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_multi_cycle();
    test_priority();
    test_mem_freeze();
    test_pending_flush();
    test_flush_abort_multi();
    test_reset_mid_multi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the five-stage MIPS32 flow CPU. Collects stall requests from ID, EX and MEM, multi-cycle EX operation starts and exception/branch flush requests. Produces a per-stage stall vector that freezes the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC, plus a flush strobe with redirect PC. Holds the multi-cycle counter and a pending-flush latch so that a flush never lands in the middle of a MEM bus transaction.

## Interface
- No parameters.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- stallreq_id  in  1  ID hazard (load-use) stall request
- stallreq_ex  in  1  EX stall request (single-cycle hold)
- stallreq_mem  in  1  MEM data-bus wait
- ex_mc_start  in  1  EX begins a multi-cycle op this cycle
- ex_mc_len  in  4  total EX cycles for that op, 0..15
- flush_req  in  1  flush pipeline, redirect to flush_pc
- flush_pc  in  32  redirect target
- stall  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB (reserved, always follows [4])
- flush  out  1  clear all pipeline registers this cycle
- new_pc  out  32  redirect PC, valid when flush=1, else 0
- mc_busy  out  1  multi-cycle op in progress (MULTI state)
- mc_last  out  1  final stall cycle of a multi-cycle op

## Operation
- States: RUN, MULTI, PFLUSH. Registers: state, mc_cnt[3:0], pend_pc[31:0].
- Stall codes: ID → 6'b000111, EX → 6'b001111, MEM → 6'b111111. Priority: flush > MEM > EX (stallreq_ex, mc start, MULTI) > ID. Stall is 0 in a flush cycle.
- RUN:
  - flush_req & !stallreq_mem → flush=1, new_pc=flush_pc, stay RUN.
  - flush_req & stallreq_mem → pend_pc←flush_pc, → PFLUSH; stall=MEM code this cycle.
  - ex_mc_start with len 0 → ignored. Len 1 → EX stall this cycle, mc_last=1, stay RUN. Len N≥2 → EX stall, mc_cnt←N-1, → MULTI. Start is ignored if flush or stallreq_mem is active.
- MULTI:
  - Stall ≥ EX code; mc_busy=1.
  - stallreq_mem freezes mc_cnt and outputs the MEM code.
  - Otherwise mc_cnt decrements. When mc_cnt==1 and not frozen: mc_last=1, → RUN.
  - flush_req: handled exactly as in RUN; the multi-cycle op is aborted and mc_cnt←0.
- PFLUSH:
  - Stall = MEM code while stallreq_mem=1.
  - First cycle with stallreq_mem=0: flush=1, new_pc=pend_pc, → RUN.
  - flush_req while in PFLUSH is ignored (older request wins).
- ex_mc_start while already in MULTI is ignored.

## Timing
- stall, flush, new_pc, mc_last are combinational from inputs plus registered state, so they take effect in the same cycle as the request. State updates on the next rising edge.
- Multi-cycle op of length N with no MEM stalls: exactly N consecutive cycles with stall[3]=1, mc_last in cycle N.
- Pending flush: flush fires in the first cycle stallreq_mem is low, i.e. zero extra cycles after the bus releases.
- Reset (rst=0, any time, including mid-MULTI or PFLUSH):
  - state→RUN, mc_cnt→0, pend_pc→0.
  - All outputs are forced 0 while rst=0, regardless of inputs.
  - First active cycle after release is RUN.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds input perf_clr (1) and outputs perf_stall_cycles (32) and perf_flush_cnt (32).
  - perf_stall_cycles counts cycles with stall[0]=1; perf_flush_cnt counts flush=1 cycles.
  - Both counters saturate at 32'hFFFFFFFF, clear synchronously on perf_clr and asynchronously on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset mid-MULTI: start len=5, assert rst=0 in cycle 3 → stall=0, mc_busy=0 immediately. After release, stall=0 with no requests.
- Multi-cycle: ex_mc_start, len=4 → stall=6'b001111 for 4 cycles, mc_last only in cycle 4, mc_busy in cycles 2–4. Len=0 → stall stays 0.
- Priority: stallreq_id=1 and stallreq_ex=1 together → 6'b001111. Add stallreq_mem=1 → 6'b111111. Add flush_req=1 (mem low) → stall=0, flush=1.
- MEM freeze in MULTI: len=3 with stallreq_mem high for 2 cycles in cycle 2 → 5 total stall cycles, mc_last in cycle 5.
- Pending flush:
  - flush_req, pc=32'h0000_0040, while stallreq_mem is high for 3 cycles → flush=0 during those cycles.
  - Then flush=1 with new_pc=32'h40 in cycle 4.
  - A second flush_req (pc 32'h80) during the wait is ignored.
- Flush aborts MULTI: len=6, flush_req in cycle 2 → flush=1, mc_busy=0 next cycle, no mc_last. With PIPE_CTRL_PERF_EN, perf_flush_cnt increments by 1.
